// File: rtl/sig_phase_sched.sv
// Round-robin phase scheduler: one green right-of-way, timed yellow and all-red handovers.
// Optional emergency preemption enabled by defining SIG_PREEMPT_EN.
module sig_phase_sched #(
    parameter int NPH       = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    localparam int PW       = (NPH > 1) ? $clog2(NPH) : 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [NPH-1:0]   req,
`ifdef SIG_PREEMPT_EN
    input  logic             preempt,
    input  logic [PW-1:0]    preempt_ph,
`endif
    output logic [2*NPH-1:0] lights,
    output logic [NPH-1:0]   grant,
    output logic             phase_done
);

    localparam int TW = $clog2(MAX_GREEN + 1);

    localparam logic [TW-1:0] MIN_G    = TW'(MIN_GREEN);
    localparam logic [TW-1:0] MAX_G    = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YEL_LOAD = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LOAD  = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_ZERO   = '0;

    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALLRED
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [PW-1:0] last;
    logic [PW-1:0] owner;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic          sel_found;
    logic [PW-1:0] sel_idx;
    logic          others;
    logic          own_req;
    logic          contested;
    logic          green_exit;
    int            probe;

    function automatic logic [2*NPH-1:0] lamp(input logic [PW-1:0] idx, input logic [1:0] code);
        lamp = '0;
        lamp[2*int'(idx) +: 2] = code;
    endfunction

    function automatic logic [NPH-1:0] onehot(input logic [PW-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Round-robin search starting just after the last-served approach, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = 0;
        for (int i = 1; i <= NPH; i++) begin
            probe = (int'(last) + i) % NPH;
            if (!win_found && req[probe]) begin
                win_found = 1'b1;
                win_idx   = PW'(probe);
            end
        end
    end

    always_comb begin
        others    = (req & ~grant) != '0;
        own_req   = (req & grant) != '0;
        contested = others && (((timer >= MIN_G) && !own_req) || (timer >= MAX_G));
`ifdef SIG_PREEMPT_EN
        sel_found  = preempt || win_found;
        sel_idx    = preempt ? preempt_ph : win_idx;
        green_exit = preempt ? (preempt_ph != owner) : contested;
`else
        sel_found  = win_found;
        sel_idx    = win_idx;
        green_exit = contested;
`endif
    end

    // Single shared timer: counts green age upward, counts yellow/all-red down to zero.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= S_IDLE;
            timer      <= T_ZERO;
            last       <= PW'(NPH - 1);
            owner      <= '0;
            lights     <= '0;
            grant      <= '0;
            phase_done <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        state  <= S_GREEN;
                        owner  <= sel_idx;
                        last   <= sel_idx;
                        grant  <= onehot(sel_idx);
                        lights <= lamp(sel_idx, LAMP_GREEN);
                        timer  <= T_ONE;
                    end
                end
                S_GREEN: begin
                    if (green_exit) begin
                        state  <= S_YELLOW;
                        lights <= lamp(owner, LAMP_YELLOW);
                        timer  <= YEL_LOAD;
                    end else if (timer < MAX_G) begin
                        timer <= timer + T_ONE;
                    end
                end
                S_YELLOW: begin
                    if (timer == T_ZERO) begin
                        state      <= S_ALLRED;
                        lights     <= '0;
                        grant      <= '0;
                        timer      <= AR_LOAD;
                        phase_done <= (ALLRED_T == 1);
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_ALLRED: begin
                    if (timer == T_ZERO) begin
                        if (sel_found) begin
                            state  <= S_GREEN;
                            owner  <= sel_idx;
                            last   <= sel_idx;
                            grant  <= onehot(sel_idx);
                            lights <= lamp(sel_idx, LAMP_GREEN);
                            timer  <= T_ONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer      <= timer - T_ONE;
                        phase_done <= (timer == T_ONE);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    lights <= '0;
                    grant  <= '0;
                    timer  <= T_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_phase_sched.sv
// Scoreboard bench for sig_phase_sched: a phase-level reference model predicts each cycle's
// lamps, owner and phase_done; a negedge monitor compares them against the DUT.
module tb_sig_phase_sched;

   localparam int NPH       = 4;
   localparam int MIN_GREEN = 4;
   localparam int MAX_GREEN = 16;
   localparam int YELLOW_T  = 3;
   localparam int ALLRED_T  = 2;

   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [7:0] lights;
   logic [3:0] grant;
   logic       phase_done;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct packed {
      logic [7:0] lights;
      logic [3:0] grant;
      logic       pd;
   } obs_t;

   obs_t expQ[$];

   // Reference state: mode 0 idle, 1 green, 2 clearance; clr counts remaining non-green cycles.
   int mMode;
   int mOwner;
   int mAge;
   int mClr;
   int mLast;

   sig_phase_sched #(
      .NPH(NPH), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
      .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
   ) dut (
      .clock(clock),
      .clear_n(clear_n),
      .req(req),
`ifdef SIG_PREEMPT_EN
      .preempt(1'b0),
      .preempt_ph(2'd0),
`endif
      .lights(lights),
      .grant(grant),
      .phase_done(phase_done)
   );

   // Free-running clock: rising edges at 5, 15, ...; outputs sampled on falling edges.
   initial begin
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pickNext(input logic [3:0] r, input int fromLast);
      int idx;
      pickNext = -1;
      for (int k = 1; k <= NPH; k++) begin
         idx = (fromLast + k) % NPH;
         if (pickNext < 0 && r[idx]) pickNext = idx;
      end
   endfunction

   function automatic obs_t modelObs();
      obs_t o;
      o = '0;
      if (mMode == 1) begin
         o.lights[2*mOwner +: 2] = 2'd2;
         o.grant[mOwner] = 1'b1;
      end else if (mMode == 2) begin
         if (mClr > ALLRED_T) begin
            o.lights[2*mOwner +: 2] = 2'd1;
            o.grant[mOwner] = 1'b1;
         end
         o.pd = (mClr == 1);
      end
      return o;
   endfunction

   // Reference model: advance one clock of phase behaviour from the sampled requests.
   always @(posedge clock) begin
      int w;
      logic others;
      if (!clear_n) begin
         mMode = 0; mOwner = 0; mAge = 0; mClr = 0; mLast = NPH - 1;
         expQ.delete();
      end else begin
         case (mMode)
            0: begin
               w = pickNext(req, mLast);
               if (w >= 0) begin
                  mOwner = w; mLast = w; mMode = 1; mAge = 1;
               end
            end
            1: begin
               others = (req & ~(4'b0001 << mOwner)) != 4'b0000;
               if (others && ((mAge >= MIN_GREEN && !req[mOwner]) || mAge >= MAX_GREEN)) begin
                  mMode = 2;
                  mClr = YELLOW_T + ALLRED_T;
               end else if (mAge < MAX_GREEN) begin
                  mAge++;
               end
            end
            default: begin
               mClr--;
               if (mClr == 0) begin
                  w = pickNext(req, mLast);
                  if (w >= 0) begin
                     mOwner = w; mLast = w; mMode = 1; mAge = 1;
                  end else begin
                     mMode = 0;
                  end
               end
            end
         endcase
         expQ.push_back(modelObs());
      end
   end

   // Monitor: during reset everything must read zero; otherwise pop one prediction per cycle.
   always @(negedge clock) begin
      obs_t e;
      if (!clear_n) begin
         checkOutput("reset_outputs", 32'({lights, grant, phase_done}), 32'd0);
      end else if (expQ.size() == 0) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL scoreboard_empty: got no prediction, expected one at %0t", $time);
      end else begin
         e = expQ.pop_front();
         checkOutput("scoreboard", 32'({lights, grant, phase_done}), 32'(e));
      end
   end

   task automatic applyStimulus(input logic [3:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         req = v;
      end
   endtask

   task automatic doReset();
      @(negedge clock);
      #1 clear_n = 1'b0;
      req = 4'b0000;
      repeat (2) @(negedge clock);
      #1 clear_n = 1'b1;
   endtask

   // Starting at a falling edge: count cycles until approach idx turns green, then its green run.
   task automatic measureRun(input int idx, input int maxLen, output int pre, output int len);
      pre = 0;
      len = 0;
      while (lights[2*idx +: 2] != 2'd2 && pre < 100) begin
         @(negedge clock);
         pre++;
      end
      while (lights[2*idx +: 2] == 2'd2 && len < maxLen) begin
         @(negedge clock);
         len++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pre;
      int len;
      logic [3:0] v;

      repeat (2) @(negedge clock);
      #1 clear_n = 1'b1;

      $display("[TB] idle with no requests");
      applyStimulus(4'b0000, 20);

      $display("[TB] single requester");
      doReset();
      applyStimulus(4'b0001, 10);
      applyStimulus(4'b0000, 40);

      $display("[TB] minimum green");
      doReset();
      @(negedge clock);
      req = 4'b0100;
      @(negedge clock);
      req = 4'b0001;
      measureRun(2, 200, pre, len);
      checkOutput("min_green_pre", 32'(pre), 32'd0);
      checkOutput("min_green_len", 32'(len), 32'(MIN_GREEN));
      measureRun(0, 10, pre, len);
      checkOutput("min_green_handover", 32'(pre), 32'(YELLOW_T + ALLRED_T));
      checkOutput("min_green_rest", 32'(len), 32'd10);

      $display("[TB] maximum green");
      doReset();
      @(negedge clock);
      req = 4'b0011;
      measureRun(0, 200, pre, len);
      checkOutput("max_green_latency", 32'(pre), 32'd1);
      checkOutput("max_green_len0", 32'(len), 32'(MAX_GREEN));
      measureRun(1, 200, pre, len);
      checkOutput("max_green_handover", 32'(pre), 32'(YELLOW_T + ALLRED_T));
      checkOutput("max_green_len1", 32'(len), 32'(MAX_GREEN));

      $display("[TB] fairness");
      doReset();
      @(negedge clock);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         measureRun(k % NPH, 200, pre, len);
         checkOutput("fair_pre", 32'(pre), (k == 0) ? 32'd1 : 32'(YELLOW_T + ALLRED_T));
         checkOutput("fair_len", 32'(len), 32'(MAX_GREEN));
      end

      $display("[TB] asynchronous reset mid-green");
      doReset();
      applyStimulus(4'b0001, 4);
      @(posedge clock);
      #2 clear_n = 1'b0;
      #1;
      checkOutput("async_reset_lights", 32'(lights), 32'd0);
      checkOutput("async_reset_grant", 32'(grant), 32'd0);
      repeat (2) @(negedge clock);
      #1 clear_n = 1'b1;

      $display("[TB] randomized requests");
      for (int c = 0; c < 80; c++) begin
         v = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) v = v & 4'(1 << $urandom_range(0, 3));
         applyStimulus(v, $urandom_range(1, 14));
         if (c == 40) doReset();
      end
      applyStimulus(4'b0000, 30);

      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
